// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the MIPS-lite multicycle controller: opcodes, ALU codes,
// state encoding, the control word and the decode-stage dispatch.
package multicycle_controller_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM    = 4'd5,
        S_LDWB   = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [ALU_OP_W-1:0] ALU_ADD   = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_SUB   = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_OR    = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_RTYPE = 3'b011;
    localparam logic [ALU_OP_W-1:0] ALU_XOR   = 3'b100;

    typedef struct packed {
        logic                mem_req;
        logic                mem_we;
        logic                iord;
        logic                ir_write;
        logic                pc_write;
        logic [1:0]          pc_src;
        logic                alu_src_a;
        logic [1:0]          alu_src_b;
        logic [ALU_OP_W-1:0] alu_op;
        logic                extend_op;
        logic [1:0]          reg_dst;
        logic [1:0]          write_reg_mux;
        logic                reg_write;
    } ctrl_t;

    // Uses the live opcode: op_q only becomes valid after DECODE.
    function automatic state_t dispatch(input logic [5:0] op, input bit trap_on_illegal);
        case (op)
            OP_RTYPE, OP_ORI, OP_XORI: dispatch = S_EXEC;
            OP_LW, OP_SW:              dispatch = S_ADDR;
            OP_BEQ:                    dispatch = S_BRANCH;
            OP_JAL:                    dispatch = S_JUMP;
            default:                   dispatch = trap_on_illegal ? S_TRAP : S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_decode.sv
// Combinational control-word map from {state, op_q, zero, mem_ready};
// stall and reset gating are applied by the parent.
module mc_ctrl_decode
    import multicycle_controller_pkg::*;
(
    input  state_t     state,
    input  logic [5:0] op_q,
    input  logic       zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = 2'd1;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_b = 2'd3;
                ctrl.extend_op = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                if (op_q == OP_RTYPE) begin
                    ctrl.alu_op = ALU_RTYPE;
                end else begin
                    ctrl.alu_src_b = 2'd2;
                    ctrl.alu_op    = (op_q == OP_XORI) ? ALU_XOR : ALU_OR;
                end
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = (op_q == OP_RTYPE) ? 2'd1 : 2'd0;
            end
            S_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'd2;
                ctrl.extend_op = 1'b1;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
                ctrl.mem_we  = (op_q == OP_SW);
            end
            S_LDWB: begin
                ctrl.reg_write     = 1'b1;
                ctrl.write_reg_mux = 2'd1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_write  = zero;
                ctrl.pc_src    = 2'd1;
            end
            S_JUMP: begin
                ctrl.pc_write      = 1'b1;
                ctrl.pc_src        = 2'd2;
                ctrl.reg_write     = 1'b1;
                ctrl.reg_dst       = 2'd2;
                ctrl.write_reg_mux = 2'd2;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle sequencer for the MIPS-lite datapath. Holds state, op_q and the
// sticky illegal flag; strobes are decoded from state by mc_ctrl_decode.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int ALU_OP_LENGTH   = 3,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [5:0]               op,
    input  logic                     zero,
    input  logic                     stall,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     iord,
    output logic                     ir_write,
    output logic                     pc_write,
    output logic [1:0]               pc_src,
    output logic                     alu_src_a,
    output logic [1:0]               alu_src_b,
    output logic [ALU_OP_LENGTH-1:0] alu_op,
    output logic                     extend_op,
    output logic [1:0]               reg_dst,
    output logic [1:0]               write_reg_mux,
    output logic                     reg_write,
    output logic                     illegal,
    output logic [3:0]               state_o
);

    state_t     state;
    logic [5:0] op_q;
    logic       illegal_q;
    logic       hold;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl;

    // FETCH and MEM ignore stall so an open memory handshake is never broken.
    assign hold = stall && (state != S_FETCH) && (state != S_MEM);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else if (!hold) begin
            case (state)
                S_FETCH:  if (mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    op_q  <= op;
                    state <= dispatch(op, TRAP_ON_ILLEGAL);
                    if (dispatch(op, TRAP_ON_ILLEGAL) == S_TRAP) illegal_q <= 1'b1;
                end
                S_EXEC:   state <= S_ALUWB;
                S_ALUWB:  state <= S_FETCH;
                S_ADDR:   state <= S_MEM;
                S_MEM:    if (mem_ready) state <= (op_q == OP_LW) ? S_LDWB : S_FETCH;
                S_LDWB:   state <= S_FETCH;
                S_BRANCH: state <= S_FETCH;
                S_JUMP:   state <= S_FETCH;
                S_TRAP:   state <= S_TRAP;
                default:  state <= S_FETCH;
            endcase
        end
    end

    mc_ctrl_decode u_decode (
        .state     (state),
        .op_q      (op_q),
        .zero      (zero),
        .mem_ready (mem_ready),
        .ctrl      (ctrl_raw)
    );

    // Reset is synchronous, so outputs are masked directly while rst_n is low.
    always_comb begin
        ctrl = ctrl_raw;
        if (hold) begin
            ctrl.pc_write  = 1'b0;
            ctrl.ir_write  = 1'b0;
            ctrl.reg_write = 1'b0;
            ctrl.mem_req   = 1'b0;
            ctrl.mem_we    = 1'b0;
        end
        if (!rst_n) ctrl = '0;
    end

    assign mem_req       = ctrl.mem_req;
    assign mem_we        = ctrl.mem_we;
    assign iord          = ctrl.iord;
    assign ir_write      = ctrl.ir_write;
    assign pc_write      = ctrl.pc_write;
    assign pc_src        = ctrl.pc_src;
    assign alu_src_a     = ctrl.alu_src_a;
    assign alu_src_b     = ctrl.alu_src_b;
    assign alu_op        = ALU_OP_LENGTH'(ctrl.alu_op);
    assign extend_op     = ctrl.extend_op;
    assign reg_dst       = ctrl.reg_dst;
    assign write_reg_mux = ctrl.write_reg_mux;
    assign reg_write     = ctrl.reg_write;
    assign illegal       = rst_n & illegal_q;
    assign state_o       = rst_n ? 4'(state) : 4'd0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed vector table, trap sequence, then
// random instruction streams against an instruction-path reference model.
module tb_multicycle_controller;

    localparam logic [5:0] RT = 6'h00, JAL = 6'h03, BEQ = 6'h04, ORI = 6'h0D;
    localparam logic [5:0] XORI = 6'h0E, LW = 6'h23, SW = 6'h2B, BAD = 6'h3F;

    logic       clk = 1'b0;
    logic       rst_n, zero, stall, mem_ready;
    logic [5:0] op;
    logic       mem_req, mem_we, iord, ir_write, pc_write, alu_src_a, extend_op, reg_write, illegal;
    logic [1:0] pc_src, alu_src_b, reg_dst, write_reg_mux;
    logic [2:0] alu_op;
    logic [3:0] state_o;

    int errors = 0;
    int checks = 0;

    multicycle_controller #(.ALU_OP_LENGTH(3), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .zero(zero), .stall(stall), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .extend_op(extend_op), .reg_dst(reg_dst), .write_reg_mux(write_reg_mux),
        .reg_write(reg_write), .illegal(illegal), .state_o(state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic       zero, stall, mr;
        logic [3:0] st;
        logic [6:0] strobes; // {mem_req, mem_we, iord, ir_write, pc_write, reg_write, illegal}
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [5:0] o, logic z, logic s, logic m,
                                logic [3:0] st, logic [6:0] sb);
        vec_t v;
        v.rst_n = r; v.op = o; v.zero = z; v.stall = s; v.mr = m; v.st = st; v.strobes = sb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] strobes_now();
        return {mem_req, mem_we, iord, ir_write, pc_write, reg_write, illegal};
    endfunction

    function automatic logic [19:0] word_now();
        return {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
                alu_op, extend_op, reg_dst, write_reg_mux, reg_write, illegal};
    endfunction

    // Drive one cycle of inputs, check at the falling edge, then cross the rising edge.
    task automatic apply(input vec_t v, input string name);
        rst_n = v.rst_n; op = v.op; zero = v.zero; stall = v.stall; mem_ready = v.mr;
        @(negedge clk);
        check({name, ".state"}, 32'(state_o), 32'(v.st));
        check({name, ".strobes"}, 32'(strobes_now()), 32'(v.strobes));
        @(posedge clk);
        #1;
    endtask

    // Reference model: each instruction class walks a fixed list of phases.
    int path_q[$];

    task automatic push_path(input logic [5:0] o);
        path_q = {0, 1};
        case (o)
            RT, ORI, XORI: path_q = {path_q, 2, 3};
            LW:            path_q = {path_q, 4, 5, 6};
            SW:            path_q = {path_q, 4, 5};
            BEQ:           path_q = {path_q, 7};
            default:       path_q = {path_q, 8};
        endcase
    endtask

    // Expected control word for a phase of an instruction with the given inputs.
    function automatic logic [19:0] model_word(input int ph, input logic [5:0] o,
                                               input logic z, input logic mr, input logic s);
        logic req = 0, we = 0, io = 0, irw = 0, pcw = 0, a = 0, ext = 0, rw = 0;
        logic [1:0] psrc = 0, b = 0, rd = 0, wm = 0;
        logic [2:0] alu = 0;
        case (ph)
            0: begin req = 1; b = 1; irw = mr; pcw = mr; end
            1: begin b = 3; ext = 1; end
            2: begin
                a = 1;
                if (o == RT) alu = 3;
                else begin b = 2; alu = (o == XORI) ? 3'd4 : 3'd2; end
            end
            3: begin rw = !s; rd = (o == RT) ? 2'd1 : 2'd0; end
            4: begin a = 1; b = 2; ext = 1; end
            5: begin req = 1; io = 1; we = (o == SW); end
            6: begin rw = !s; wm = 1; end
            7: begin a = 1; alu = 1; pcw = z && !s; psrc = 1; end
            default: begin pcw = !s; psrc = 2; rw = !s; rd = 2; wm = 2; end
        endcase
        return {req, we, io, irw, pcw, psrc, a, b, alu, ext, rd, wm, rw, 1'b0};
    endfunction

    initial begin
        vec_t v;
        logic [5:0] ops[7] = '{RT, ORI, XORI, LW, SW, BEQ, JAL};
        logic [5:0] cur_op;
        int cur, n_instr;

        rst_n = 0; op = 0; zero = 0; stall = 0; mem_ready = 1;

        // Directed table: reset, fetch wait, LW with stalled MEM, SW, BEQ both ways,
        // R-type with EXEC stall, JAL with stall, reset mid-access, decode of bad op.
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 7'b0000000));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 0, 0, 0, 7'b1000000));
        tbl.push_back(mk(1, 0,   0, 0, 1, 0, 7'b1001100));
        tbl.push_back(mk(1, LW,  0, 0, 0, 1, 7'b0000000));
        tbl.push_back(mk(1, SW,  0, 0, 0, 4, 7'b0000000));
        tbl.push_back(mk(1, SW,  0, 0, 0, 5, 7'b1010000));
        tbl.push_back(mk(1, SW,  0, 1, 1, 5, 7'b1010000));
        tbl.push_back(mk(1, SW,  0, 0, 0, 6, 7'b0000010));
        tbl.push_back(mk(1, 0,   0, 0, 1, 0, 7'b1001100));
        tbl.push_back(mk(1, SW,  0, 0, 0, 1, 7'b0000000));
        tbl.push_back(mk(1, LW,  0, 0, 0, 4, 7'b0000000));
        tbl.push_back(mk(1, LW,  0, 0, 1, 5, 7'b1110000));
        tbl.push_back(mk(1, 0,   0, 0, 1, 0, 7'b1001100));
        tbl.push_back(mk(1, BEQ, 0, 0, 0, 1, 7'b0000000));
        tbl.push_back(mk(1, 0,   1, 0, 0, 7, 7'b0000100));
        tbl.push_back(mk(1, 0,   0, 0, 1, 0, 7'b1001100));
        tbl.push_back(mk(1, BEQ, 0, 0, 0, 1, 7'b0000000));
        tbl.push_back(mk(1, 0,   0, 0, 0, 7, 7'b0000000));
        tbl.push_back(mk(1, 0,   0, 0, 1, 0, 7'b1001100));
        tbl.push_back(mk(1, RT,  0, 0, 0, 1, 7'b0000000));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 0, 0, 1, 0, 2, 7'b0000000));
        tbl.push_back(mk(1, 0,   0, 0, 0, 2, 7'b0000000));
        tbl.push_back(mk(1, 0,   0, 0, 0, 3, 7'b0000010));
        tbl.push_back(mk(1, 0,   0, 0, 1, 0, 7'b1001100));
        tbl.push_back(mk(1, JAL, 0, 0, 0, 1, 7'b0000000));
        tbl.push_back(mk(1, 0,   0, 1, 0, 8, 7'b0000000));
        tbl.push_back(mk(1, 0,   0, 0, 0, 8, 7'b0000110));
        tbl.push_back(mk(1, 0,   0, 0, 1, 0, 7'b1001100));
        tbl.push_back(mk(1, LW,  0, 0, 0, 1, 7'b0000000));
        tbl.push_back(mk(1, 0,   0, 0, 0, 4, 7'b0000000));
        tbl.push_back(mk(1, 0,   0, 0, 0, 5, 7'b1010000));
        tbl.push_back(mk(0, 0,   0, 0, 0, 0, 7'b0000000));
        tbl.push_back(mk(1, 0,   0, 0, 0, 0, 7'b1000000));
        tbl.push_back(mk(1, 0,   0, 0, 1, 0, 7'b1001100));
        tbl.push_back(mk(1, BAD, 0, 0, 0, 1, 7'b0000000));

        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // Sticky trap: no strobes, ignores memory and stall, left only by reset.
        for (int i = 0; i < 10; i++) begin
            v = mk(1, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1, 9, 7'b0000001);
            apply(v, $sformatf("trap%0d", i));
        end
        apply(mk(0, 0, 0, 0, 1, 0, 7'b0000000), "trap_reset");
        apply(mk(1, 0, 0, 0, 0, 0, 7'b1000000), "trap_release");

        // Random instruction stream; op is only meaningful during DECODE.
        n_instr = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (path_q.size() == 0) begin
                cur_op = ops[$urandom_range(0, 6)];
                push_path(cur_op);
                n_instr++;
            end
            cur = path_q[0];
            stall     = ($urandom_range(0, 3) == 0);
            mem_ready = 1'($urandom_range(0, 1));
            zero      = 1'($urandom_range(0, 1));
            op        = (cur == 1) ? cur_op : 6'($urandom_range(0, 63));
            @(negedge clk);
            check($sformatf("rand%0d.state", cyc), 32'(state_o), 32'(cur));
            check($sformatf("rand%0d.ctrl", cyc), 32'(word_now()),
                  32'(model_word(cur, cur_op, zero, mem_ready, stall)));
            @(posedge clk);
            if ((cur == 0 || cur == 5) ? mem_ready : !stall) void'(path_q.pop_front());
            #1;
        end
        check("rand_instr_count_nonzero", 32'(n_instr > 100), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
